branch_predictor: RTL and testbench



---
 rtl/branch_predictor.sv | 121 ++++++++++++
 tb/tb_branch_predictor.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/branch_predictor.sv
// rtl/branch_predictor.sv - IF-stage BTB + 2-bit BHT branch predictor with perf counters
// Optional gshare indexing enabled by defining GSHARE_EN.
module branch_predictor #(
    parameter int INDEX_BITS = 6,
    parameter int HIST_BITS  = INDEX_BITS
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [31:0]           if_pc,
    output logic                  predicted,
    output logic [31:0]           predicted_target,
    output logic [INDEX_BITS-1:0] if_bht_index,
    input  logic                  ex_update,
    input  logic [31:0]           ex_pc,
    input  logic [INDEX_BITS-1:0] ex_bht_index,
    input  logic                  ex_taken,
    input  logic [31:0]           ex_target,
    input  logic                  ex_predicted,
    output logic [31:0]           branch_count,
    output logic [31:0]           mispredict_count
);

    localparam int ENTRIES  = 1 << INDEX_BITS;
    localparam int TAG_BITS = 30 - INDEX_BITS;

    // Global history folds onto the index by XOR, so the widths must agree.
    if (HIST_BITS != INDEX_BITS) begin : g_bad_hist
        $error("branch_predictor: HIST_BITS must equal INDEX_BITS");
    end

    logic                r_btb_valid  [ENTRIES];
    logic [TAG_BITS-1:0] r_btb_tag    [ENTRIES];
    logic [31:0]         r_btb_target [ENTRIES];
    logic [1:0]          r_bht        [ENTRIES];
    logic [31:0]         r_branch_count;
    logic [31:0]         r_mispredict_count;

    logic [INDEX_BITS-1:0] w_if_idx;
    logic [TAG_BITS-1:0]   w_if_tag;
    logic [INDEX_BITS-1:0] w_ex_idx;
    logic [TAG_BITS-1:0]   w_ex_tag;
    logic                  w_hit;
    logic [1:0]            w_bht_cur;
    logic [1:0]            w_bht_next;
    logic                  w_unused;

    assign w_if_idx = if_pc[INDEX_BITS+1:2];
    assign w_if_tag = if_pc[31:INDEX_BITS+2];
    assign w_ex_idx = ex_pc[INDEX_BITS+1:2];
    assign w_ex_tag = ex_pc[31:INDEX_BITS+2];
    assign w_unused = &{1'b0, if_pc[1:0], ex_pc[1:0]};

`ifdef GSHARE_EN
    logic [HIST_BITS-1:0] r_ghr;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ghr <= '0;
        end else if (ex_update) begin
            r_ghr <= {r_ghr[HIST_BITS-2:0], ex_taken};
        end
    end

    assign if_bht_index = w_if_idx ^ r_ghr;
`else
    assign if_bht_index = w_if_idx;
`endif

    // Lookup reads only registered state, so a same-cycle update is not bypassed.
    always_comb begin
        w_hit            = r_btb_valid[w_if_idx] && (r_btb_tag[w_if_idx] == w_if_tag);
        predicted        = w_hit && r_bht[if_bht_index][1];
        predicted_target = predicted ? r_btb_target[w_if_idx] : 32'h0;
    end

    always_comb begin
        w_bht_cur  = r_bht[ex_bht_index];
        w_bht_next = w_bht_cur;
        if (ex_taken) begin
            if (w_bht_cur != 2'b11) begin
                w_bht_next = w_bht_cur + 2'b01;
            end
        end else begin
            if (w_bht_cur != 2'b00) begin
                w_bht_next = w_bht_cur - 2'b01;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < ENTRIES; i++) begin
                r_btb_valid[i]  <= 1'b0;
                r_btb_tag[i]    <= '0;
                r_btb_target[i] <= 32'h0;
                r_bht[i]        <= 2'b01;
            end
        end else if (ex_update) begin
            r_btb_valid[w_ex_idx]  <= 1'b1;
            r_btb_tag[w_ex_idx]    <= w_ex_tag;
            r_btb_target[w_ex_idx] <= ex_target;
            r_bht[ex_bht_index]    <= w_bht_next;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_branch_count     <= 32'h0;
            r_mispredict_count <= 32'h0;
        end else if (ex_update) begin
            r_branch_count <= r_branch_count + 32'h1;
            if (ex_predicted != ex_taken) begin
                r_mispredict_count <= r_mispredict_count + 32'h1;
            end
        end
    end

    assign branch_count     = r_branch_count;
    assign mispredict_count = r_mispredict_count;

endmodule

// File: tb/tb_branch_predictor.sv
// tb/tb_branch_predictor.sv - randomized self-checking bench for branch_predictor
module tb_branch_predictor;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] if_pc;
    logic        predicted;
    logic [31:0] predicted_target;
    logic [5:0]  if_bht_index;
    logic        ex_update;
    logic [31:0] ex_pc;
    logic [5:0]  ex_bht_index;
    logic        ex_taken;
    logic [31:0] ex_target;
    logic        ex_predicted;
    logic [31:0] branch_count;
    logic [31:0] mispredict_count;

    int n_vec = 0;
    int n_err = 0;

    bit          m_valid [64];
    int unsigned m_tag   [64];
    int unsigned m_tgt   [64];
    int          m_bht   [64];
    int unsigned m_br;
    int unsigned m_mis;
    int unsigned m_ghr;

    always #5 clk = ~clk;

    branch_predictor #(.INDEX_BITS(6)) dut (
        .clk              (clk),
        .reset            (reset),
        .if_pc            (if_pc),
        .predicted        (predicted),
        .predicted_target (predicted_target),
        .if_bht_index     (if_bht_index),
        .ex_update        (ex_update),
        .ex_pc            (ex_pc),
        .ex_bht_index     (ex_bht_index),
        .ex_taken         (ex_taken),
        .ex_target        (ex_target),
        .ex_predicted     (ex_predicted),
        .branch_count     (branch_count),
        .mispredict_count (mispredict_count)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 64; i++) begin
            m_valid[i] = 1'b0;
            m_tag[i]   = 0;
            m_tgt[i]   = 0;
            m_bht[i]   = 1;
        end
        m_br  = 0;
        m_mis = 0;
        m_ghr = 0;
    endtask

    function automatic int unsigned exp_index(input int unsigned pc);
`ifdef GSHARE_EN
        return ((pc / 4) % 64) ^ m_ghr;
`else
        return (pc / 4) % 64;
`endif
    endfunction

    task automatic check_lookup(input string tag);
        int unsigned idx;
        int unsigned bidx;
        bit          pred;
        idx  = (if_pc / 4) % 64;
        bidx = exp_index(if_pc);
        pred = m_valid[idx] && (m_tag[idx] == if_pc / 256) && (m_bht[bidx] >= 2);
        check({tag, ".pred"},   {31'b0, predicted}, {31'b0, pred});
        check({tag, ".target"}, predicted_target, pred ? m_tgt[idx] : 32'h0);
        check({tag, ".index"},  {26'b0, if_bht_index}, bidx);
        check({tag, ".brcnt"},  branch_count, m_br);
        check({tag, ".miscnt"}, mispredict_count, m_mis);
    endtask

    task automatic model_update();
        int unsigned idx;
        idx          = (ex_pc / 4) % 64;
        m_valid[idx] = 1'b1;
        m_tag[idx]   = ex_pc / 256;
        m_tgt[idx]   = ex_target;
        if (ex_taken) m_bht[ex_bht_index] = (m_bht[ex_bht_index] == 3) ? 3 : m_bht[ex_bht_index] + 1;
        else          m_bht[ex_bht_index] = (m_bht[ex_bht_index] == 0) ? 0 : m_bht[ex_bht_index] - 1;
        m_br = m_br + 1;
        if (ex_predicted != ex_taken) m_mis = m_mis + 1;
        m_ghr = ((m_ghr * 2) + (ex_taken ? 1 : 0)) % 64;
    endtask

    // Inputs are applied 1ns after a rising edge, outputs sampled mid-cycle.
    task automatic cycle(input string tag, input logic [31:0] pc, input logic upd,
                         input logic [31:0] epc, input logic tk, input logic [31:0] tgt,
                         input logic epred);
        if_pc        = pc;
        ex_update    = upd;
        ex_pc        = epc;
        ex_bht_index = 6'(exp_index(epc));
        ex_taken     = tk;
        ex_target    = tgt;
        ex_predicted = epred;
        #4;
        check_lookup(tag);
        @(posedge clk);
        if (upd) model_update();
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        model_reset();
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        reset        = 1'b1;
        if_pc        = 32'h100;
        ex_update    = 1'b0;
        ex_pc        = 32'h0;
        ex_bht_index = 6'h0;
        ex_taken     = 1'b0;
        ex_target    = 32'h0;
        ex_predicted = 1'b0;
        do_reset();

        cycle("rst", 32'h100, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        check("rst.pred_const", {31'b0, predicted}, 32'h0);

        // Same-cycle lookup of the entry being trained sees the old state.
        cycle("train1", 32'h100, 1'b1, 32'h100, 1'b1, 32'h80, 1'b0);
        cycle("after1", 32'h100, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
`ifndef GSHARE_EN
        check("after1.pred_const",   {31'b0, predicted}, 32'h1);
        check("after1.target_const", predicted_target, 32'h80);
        check("after1.mis_const",    mispredict_count, 32'h1);
`endif

        for (int i = 0; i < 3; i++)
            cycle("sat", 32'h100, 1'b1, 32'h100, 1'b1, 32'h80, 1'b1);
        cycle("nt", 32'h100, 1'b1, 32'h100, 1'b0, 32'h80, 1'b1);
        cycle("post_nt", 32'h100, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
`ifndef GSHARE_EN
        check("post_nt.pred_const",  {31'b0, predicted}, 32'h1);
        check("post_nt.brcnt_const", branch_count, 32'h5);
`endif

        cycle("alias", 32'h100, 1'b1, 32'h200, 1'b1, 32'h3C0, 1'b1);
        cycle("miss100", 32'h100, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        cycle("hit200", 32'h200, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);

        // Asynchronous reset mid-cycle must clear outputs before the next edge.
        if_pc     = 32'h200;
        ex_update = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        check("async.pred",   {31'b0, predicted}, 32'h0);
        check("async.target", predicted_target, 32'h0);
        check("async.brcnt",  branch_count, 32'h0);
        check("async.miscnt", mispredict_count, 32'h0);
        check("async.index",  {26'b0, if_bht_index}, (32'h200 / 4) % 64);
        model_reset();
        @(posedge clk);
        #1;
        reset = 1'b0;
        cycle("postrst", 32'h200, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);

        for (int n = 0; n < 400; n++) begin
            logic [31:0] pc;
            logic [31:0] epc;
            pc  = {22'($urandom_range(0, 3)), 3'b0, 3'($urandom_range(0, 7)), 2'b00, 2'b00};
            epc = {22'($urandom_range(0, 3)), 3'b0, 3'($urandom_range(0, 7)), 2'b00, 2'b00};
            cycle("rand", pc, 1'($urandom_range(0, 2) != 0), epc, 1'($urandom),
                  $urandom, 1'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
